ps2_key_sequencer: RTL and testbench
====================================

Name: ps2_key_sequencer

Overview:
- Sequences raw PS/2 scan-code bytes from the PS/2 receiver through the shared combinational scan-code-to-ASCII converter.
- Decodes make/break (F0) and extended (E0) prefixes and tracks Shift state.
- Applies the letter case rule and buffers the resulting ASCII characters in a small FIFO with a valid/ready handshake toward the text/calculator front end.

Parameters:
- FIFO_DEPTH, 8, ASCII output FIFO entries; power of 2, 2..32.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- scan_code  input  8  byte from the PS/2 receiver.
- scan_valid  input  1  one-cycle strobe; scan_code is valid this cycle.
- lut_code  output  8  registered code driven to the converter's scan-code input.
- lut_ascii  input  8  converter result for lut_code (combinational, same cycle).
- ascii_data  output  8  FIFO head character.
- ascii_valid  output  1  FIFO not empty.
- ascii_ready  input  1  consumer accepts head when ascii_valid & ascii_ready.
- shift_held  output  1  left or right Shift currently down.
- overflow  output  1  sticky; character or scan byte dropped.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset: all state forced immediately, regardless of the current state or any in-flight character.
  - State = IDLE.
  - lut_code = 8'h00, shift_held = 0, overflow = 0.
  - FIFO emptied, so ascii_valid = 0 and ascii_data = 8'h00.
  - Pending lookup is discarded.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0), LOOKUP.
- Transitions on scan_valid:
  - IDLE:
    - F0 -> BRK.
    - E0 -> EXT.
    - 12/59 -> set the corresponding shift bit, stay IDLE.
    - Any other code -> load lut_code, go to LOOKUP.
  - BRK:
    - 12/59 -> clear the corresponding shift bit.
    - Any other code is ignored.
    - Always -> IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - 4A -> push 8'h2F ('/').
    - 5A -> push 8'h0A.
    - 12/59 (fake shift) and all other codes -> no push, shift unchanged.
    - Always -> IDLE (except F0).
  - EXT_BRK: any byte -> IDLE, no effect.
  - LOOKUP: one cycle only, no scan_valid needed. Captures lut_ascii, applies the rules below, pushes the result, then -> IDLE.
- scan_valid while in LOOKUP: the byte is dropped and overflow is set.
- Shift state:
  - shift_held = left_bit | right_bit.
  - lut_code is the only input the converter sees.
  - Shift modifies output only through the case rule below.
- Case rule in LOOKUP, applied to c = lut_ascii:
  - c == 8'h00 -> no push (covers Shift and unmapped codes).
  - c in 8'h41..8'h5A and shift_held == 0 -> push c + 8'h20 (lowercase).
  - Otherwise -> push c.
- Latency:
  - Non-extended key: make byte strobed in cycle N -> character visible at ascii_data with ascii_valid = 1 in cycle N+2 (FIFO empty, no back-pressure).
  - Extended push: visible in cycle N+1.
- FIFO:
  - First-word-fall-through; ascii_data = mem[rd_ptr].
  - Pop when ascii_valid & ascii_ready.
  - Pointers use one extra wrap bit and wrap modulo 2*FIFO_DEPTH.
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the push is dropped and overflow is set.
  - Simultaneous push and pop on an empty FIFO: no pop (valid was 0); the push is accepted.
- overflow:
  - Set has priority over clr_overflow in the same cycle.
  - Stays set until cleared or reset.
- Typematic repeat (repeated make bytes without break): each repeat is a new character.

Test Plan:
- Letter without Shift: reset, then 1C -> ascii_valid in cycle N+2 with ascii_data = 8'h61. Then F0 1C -> no further output.
- Letter with Shift: 12, 1C, F0 1C, F0 12, 1C -> outputs 8'h41 then 8'h61; shift_held = 1 between 12 and F0 12, 0 otherwise.
- Extended keys: E0 4A, E0 F0 4A, E0 5A -> outputs 8'h2F, 8'h0A only. Also E0 12 -> shift_held stays 0.
- FIFO fill: ascii_ready = 0, 9 presses of 16 with FIFO_DEPTH = 8 -> 8 entries of 8'h31, overflow = 1. Raise ascii_ready -> 8 pops on consecutive cycles, then ascii_valid = 0.
- Full with simultaneous push and pop: FIFO full, ascii_ready = 1 in the LOOKUP cycle -> push accepted, overflow stays 0. Also clr_overflow and a set in the same cycle -> overflow = 1.
- Reset mid-sequence: F0, then rst pulse, then 1C -> 8'h61 output; the break prefix is forgotten and the FIFO is empty before 1C.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ps2_key_sequencer
// Purpose : PS/2 scan-code sequencer with prefix decode, Shift tracking, case
//           rule and first-word-fall-through ASCII output FIFO.
// Revision: 1.0
// ============================================================================
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] lut_code,
  input  logic [7:0] lut_ascii,
  output logic [7:0] ascii_data,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       shift_held,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BRK     = 3'd1,
    EXT     = 3'd2,
    EXT_BRK = 3'd3,
    LOOKUP  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     lut_code_q, lut_code_d;
  logic           shift_l_q, shift_l_d;
  logic           shift_r_q, shift_r_d;
  logic           overflow_q, overflow_d;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]     mem_q [FIFO_DEPTH];

  logic       push;
  logic [7:0] push_data;
  logic       drop_scan;
  logic       fifo_empty, fifo_full, pop, push_ok;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = !fifo_empty && ascii_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push && (!fifo_full || pop);

  assign lut_code    = lut_code_q;
  assign shift_held  = shift_l_q | shift_r_q;
  assign overflow    = overflow_q;
  assign ascii_valid = !fifo_empty;
  assign ascii_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    state_d    = state_q;
    lut_code_d = lut_code_q;
    shift_l_d  = shift_l_q;
    shift_r_d  = shift_r_q;
    push       = 1'b0;
    push_data  = 8'h00;
    drop_scan  = 1'b0;
    case (state_q)
      IDLE: if (scan_valid) begin
        case (scan_code)
          8'hF0:   state_d = BRK;
          8'hE0:   state_d = EXT;
          8'h12:   shift_l_d = 1'b1;
          8'h59:   shift_r_d = 1'b1;
          default: begin
            lut_code_d = scan_code;
            state_d    = LOOKUP;
          end
        endcase
      end
      BRK: if (scan_valid) begin
        if (scan_code == 8'h12) shift_l_d = 1'b0;
        if (scan_code == 8'h59) shift_r_d = 1'b0;
        state_d = IDLE;
      end
      EXT: if (scan_valid) begin
        state_d = IDLE;
        case (scan_code)
          8'hF0:   state_d = EXT_BRK;
          8'h4A:   begin push = 1'b1; push_data = 8'h2F; end
          8'h5A:   begin push = 1'b1; push_data = 8'h0A; end
          default: ;
        endcase
      end
      EXT_BRK: if (scan_valid) state_d = IDLE;
      LOOKUP: begin
        drop_scan = scan_valid;
        state_d   = IDLE;
        if (lut_ascii != 8'h00) begin
          push = 1'b1;
          if (lut_ascii >= 8'h41 && lut_ascii <= 8'h5A && !shift_held)
            push_data = lut_ascii + 8'h20;
          else
            push_data = lut_ascii;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    // Setting wins over a clear in the same cycle.
    if (drop_scan || (push && !push_ok)) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lut_code_q <= 8'h00;
      shift_l_q  <= 1'b0;
      shift_r_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lut_code_q <= lut_code_d;
      shift_l_q  <= shift_l_d;
      shift_r_q  <= shift_r_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_sequencer.sv
`default_nettype none
// Directed bench for ps2_key_sequencer; the bench supplies the scan-code converter.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [7:0] lut_code;
  logic [7:0] lut_ascii;
  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       ascii_ready = 1'b0;
  logic       shift_held;
  logic       overflow;
  logic       clr_overflow = 1'b0;

  int total = 0;
  int bad   = 0;

  ps2_key_sequencer #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
    .lut_code(lut_code), .lut_ascii(lut_ascii), .ascii_data(ascii_data),
    .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .shift_held(shift_held), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (lut_code)
      8'h1C:   lut_ascii = 8'h41;
      8'h16:   lut_ascii = 8'h31;
      8'h4A:   lut_ascii = 8'h2F;
      default: lut_ascii = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Strobe one byte; returns 1 time unit after the edge that sampled it.
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    scan_code = b; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total += 5;
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ascii_valid); end
    if (ascii_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", ascii_data); end
    if (lut_code !== 8'h00) begin bad++; $display("FAIL reset_lut got=%h exp=00", lut_code); end
    if (shift_held !== 1'b0) begin bad++; $display("FAIL reset_shift got=%b exp=0", shift_held); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_letter_plain();
    send(8'h1C);
    total += 3;
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL plain_early got=%b exp=0", ascii_valid); end
    tick();
    if (ascii_valid !== 1'b1) begin bad++; $display("FAIL plain_valid got=%b exp=1", ascii_valid); end
    if (ascii_data !== 8'h61) begin bad++; $display("FAIL plain_data got=%h exp=61", ascii_data); end
    ascii_ready = 1'b1; tick(); ascii_ready = 1'b0;
    send(8'hF0); send(8'h1C);
    repeat (3) tick();
    total++;
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL plain_break got=%b exp=0", ascii_valid); end
  endtask

  task automatic test_letter_shift();
    send(8'h12);
    total++;
    if (shift_held !== 1'b1) begin bad++; $display("FAIL shift_set got=%b exp=1", shift_held); end
    send(8'h1C); send(8'hF0); send(8'h1C);
    total++;
    if (shift_held !== 1'b1) begin bad++; $display("FAIL shift_kept got=%b exp=1", shift_held); end
    send(8'hF0); send(8'h12);
    total++;
    if (shift_held !== 1'b0) begin bad++; $display("FAIL shift_clr got=%b exp=0", shift_held); end
    send(8'h1C); tick();
    total += 3;
    if (ascii_data !== 8'h41) begin bad++; $display("FAIL shift_upper got=%h exp=41", ascii_data); end
    ascii_ready = 1'b1; tick();
    if (ascii_data !== 8'h61) begin bad++; $display("FAIL shift_lower got=%h exp=61", ascii_data); end
    tick(); ascii_ready = 1'b0;
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL shift_empty got=%b exp=0", ascii_valid); end
  endtask

  task automatic test_extended();
    send(8'hE0); send(8'h4A);
    total += 2;
    if (ascii_valid !== 1'b1) begin bad++; $display("FAIL ext_latency got=%b exp=1", ascii_valid); end
    if (ascii_data !== 8'h2F) begin bad++; $display("FAIL ext_slash got=%h exp=2F", ascii_data); end
    send(8'hE0); send(8'hF0); send(8'h4A);
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'h12);
    tick();
    total += 4;
    if (shift_held !== 1'b0) begin bad++; $display("FAIL ext_fake_shift got=%b exp=0", shift_held); end
    ascii_ready = 1'b1; tick();
    if (ascii_data !== 8'h0A) begin bad++; $display("FAIL ext_enter got=%h exp=0A", ascii_data); end
    tick(); ascii_ready = 1'b0;
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL ext_empty got=%b exp=0", ascii_valid); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL ext_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_fifo_fill();
    for (int i = 0; i < 9; i++) send(8'h16);
    tick();
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    if (ascii_valid !== 1'b1) begin bad++; $display("FAIL fill_valid got=%b exp=1", ascii_valid); end
    ascii_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ascii_valid !== 1'b1 || ascii_data !== 8'h31) begin
        bad++; $display("FAIL fill_pop%0d got=%b/%h exp=1/31", i, ascii_valid, ascii_data);
      end
      tick();
    end
    ascii_ready = 1'b0;
    total++;
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL fill_drained got=%b exp=0", ascii_valid); end
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL fill_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) send(8'h16);
    send(8'h1C);
    ascii_ready = 1'b1; tick();
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (ascii_data !== 8'h31) begin bad++; $display("FAIL fpp_pop%0d got=%h exp=31", i, ascii_data); end
      tick();
    end
    total += 2;
    if (ascii_data !== 8'h61) begin bad++; $display("FAIL fpp_last got=%h exp=61", ascii_data); end
    tick();
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%b exp=0", ascii_valid); end
    ascii_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h16);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL fpp_set_wins got=%b exp=1", overflow); end
    ascii_ready = 1'b1; repeat (8) tick(); ascii_ready = 1'b0;
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
  endtask

  task automatic test_lookup_collision();
    @(posedge clk); #1;
    scan_code = 8'h1C; scan_valid = 1'b1;
    @(posedge clk); #1;
    scan_code = 8'h16;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    tick();
    total += 3;
    if (overflow !== 1'b1) begin bad++; $display("FAIL coll_ovf got=%b exp=1", overflow); end
    if (ascii_data !== 8'h61) begin bad++; $display("FAIL coll_data got=%h exp=61", ascii_data); end
    ascii_ready = 1'b1; tick(); ascii_ready = 1'b0;
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL coll_single got=%b exp=0", ascii_valid); end
  endtask

  task automatic test_reset_mid();
    send(8'h12); send(8'h16); send(8'hF0);
    #2 rst = 1'b1;
    #1;
    total += 4;
    if (ascii_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", ascii_valid); end
    if (shift_held !== 1'b0) begin bad++; $display("FAIL rmid_shift got=%b exp=0", shift_held); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b exp=0", overflow); end
    if (ascii_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h exp=00", ascii_data); end
    tick(); rst = 1'b0;
    send(8'h1C); tick();
    total += 2;
    if (ascii_valid !== 1'b1) begin bad++; $display("FAIL rmid_after_valid got=%b exp=1", ascii_valid); end
    if (ascii_data !== 8'h61) begin bad++; $display("FAIL rmid_after_data got=%h exp=61", ascii_data); end
  endtask

  initial begin
    test_reset();
    test_letter_plain();
    test_letter_shift();
    test_extended();
    test_fifo_fill();
    test_full_push_pop();
    test_lookup_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
